sipo_word_collector: RTL
========================

Name: sipo_word_collector

Overview:
- Downstream companion of the 4-bit parallel-in/serial-out shifter. Consumes its MSB-first serial stream and reassembles WIDTH-bit words.
- Completed words go into a small show-ahead output FIFO, read through a valid/ready handshake.
- Provides word-boundary realignment and a sticky overflow flag, so lost words are visible to the consumer.

Parameters:
- WIDTH, 4, serial word length in bits (>=2); must match the upstream shifter width.
- DEPTH, 2, output FIFO depth in words (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- sin  input  1  serial data bit, MSB first
- sin_en  input  1  sample qualifier; sin is captured only when high
- align  input  1  synchronous word-boundary restart; discards the partial word
- dout  output  WIDTH  head-of-FIFO word
- dout_valid  output  1  dout holds a valid word
- dout_ready  input  1  consumer accepts dout this cycle
- level  output  $clog2(DEPTH)+1  words currently held in the FIFO
- overflow  output  1  sticky: a completed word was dropped
- ovf_clr  input  1  clears overflow

Behaviour:
- Reset (rst=0, asynchronous): shift register=0, bit count=0, FIFO empty, dout=0, dout_valid=0, level=0, overflow=0.
- Shift: on a clk edge with sin_en=1 and align=0, sreg <= {sreg[WIDTH-2:0], sin} and count increments.
- Word complete: when count==WIDTH-1 and a bit is captured.
  - Word = {sreg[WIDTH-2:0], sin} is pushed.
  - count wraps to 0. The next bit starts a new word with no gap cycle.
- Latency: the word is on dout with dout_valid=1 in the cycle after the edge that captured its last bit, when the FIFO was empty.
- FIFO is show-ahead:
  - dout always shows the oldest word.
  - dout is 0 when empty.
- Pop: happens when dout_valid && dout_ready at the clk edge. dout_ready while empty is ignored.
- dout/dout_valid stay stable while dout_valid=1 and dout_ready=0.
- Simultaneous push and pop:
  - When not empty, both happen and level is unchanged.
  - When empty, the push is accepted. dout_valid rises next cycle; no bypass in the same cycle.
- Full (level==DEPTH):
  - Push with a pop in the same cycle: accepted.
  - Push without a pop: the word is dropped, FIFO contents are untouched, overflow <= 1.
- overflow stays set until an ovf_clr cycle. If set and clear occur in the same cycle, set wins.
- align=1:
  - count <= 0 and sreg <= 0.
  - Any sin bit that cycle is discarded, even if sin_en=1.
  - FIFO, dout and overflow are unaffected.
  - align has priority over sin_en.
- sin_en=0 cycles freeze count and sreg: stalls may occur mid-word without corrupting it.
- Reset mid-word or with a non-empty FIFO: the partial word and all stored words are lost, and every output returns to its reset value immediately.
- level = number of stored words, 0..DEPTH.

Test Plan:
- WIDTH=4. After reset, drive sin=1,0,1,1 with sin_en=1 on 4 consecutive edges, dout_ready=0 -> cycle after the 4th edge: dout=4'b1011, dout_valid=1, level=1. Then dout_ready=1 for one edge -> dout_valid=0, level=0.
- Stall: bits 1,1 then sin_en=0 for 3 cycles then bits 0,1 -> single word 4'b1101. No word is produced during the stall.
- Back-to-back: 12 continuous bits 1011_0110_1111 with dout_ready=1 -> words 1011, 0110, 1111 appear in order, each one cycle after its last bit. overflow stays 0.
- Overflow: DEPTH=2, dout_ready=0, stream three words 0001, 0010, 0011 -> level=2, dout=0001, overflow=1. Pop twice -> 0001, then 0010; 0011 is absent.
  - Assert ovf_clr -> overflow=0.
  - Repeat the overflow with ovf_clr held high during the drop -> overflow=1.
- Full with a simultaneous pop: level=2, dout_ready=1 on the edge that completes word 0100 -> level stays 2, 0100 is retained, overflow=0.
- align mid-word: bits 1,1 then align=1 with sin_en=1, sin=1, then bits 0,0,1,0 -> single word 0010. Then assert rst=0 asynchronously with level=1 -> dout_valid=0, dout=0, level=0 before the next clk edge.

Source files
------------

// File: rtl/sipo_word_collector.sv
// Serial-in/parallel-out word collector: rebuilds MSB-first WIDTH-bit words from a
// qualified serial stream and queues them in a show-ahead FIFO with sticky overflow.
module sipo_word_collector #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sin,
    input  logic                     sin_en,
    input  logic                     align,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    // Only the WIDTH-1 most recent bits need storing; the last bit completes the word directly.
    logic [WIDTH-2:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;

    logic             cap;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // Bit capture and word assembly.
    always_comb begin
        cap       = sin_en && !align;
        word      = {sreg_q, sin};
        word_done = cap && (count_q == CNT_W'(WIDTH - 1));
        sreg_d    = sreg_q;
        count_d   = count_q;
        if (align) begin
            sreg_d  = '0;
            count_d = '0;
        end else if (cap) begin
            sreg_d  = word[WIDTH-2:0];
            count_d = word_done ? '0 : count_q + CNT_W'(1);
        end
    end

    // FIFO bookkeeping: a push into a full FIFO survives only if the head leaves this cycle.
    always_comb begin
        full       = (level_q == LVL_W'(DEPTH));
        pop        = valid_q && dout_ready;
        push       = word_done && (!full || pop);
        drop       = word_done && full && !pop;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push) begin
            mem_d[wr_ptr_q] = word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Registered show-ahead head: next-cycle oldest word, zero when empty.
    always_comb begin
        valid_d = (level_d != '0);
        dout_d  = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sreg_q     <= sreg_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            mem_q      <= mem_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;

endmodule
